kernel_pr_fifo_srl_stat: RTL and testbench
==========================================

// Module: kernel_pr_fifo_srl_stat
// PURPOSE
// - Parametrised shift-register FIFO for inter-process start tokens and narrow dataflow streams.
// - Successor to the fixed 1-bit/depth-4 start FIFOs.
// - Adds over its predecessor:
//   - arbitrary DEPTH, including non-power-of-2 and DEPTH=1;
//   - an occupancy count output;
//   - programmable almost-full / almost-empty flags;
//   - an optional read+write-when-full mode;
//   - sticky overflow/underflow error flags for debug.
// - Sits between HLS dataflow processes; uses the same if_* handshake.
// PARAMETERS
// - DATA_WIDTH     1  payload width, bits (>=1)
// - DEPTH          4  entries (>=1)
// - AF_LEVEL       3  if_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL       1  if_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
// - RW_WHEN_FULL   0  1: a write is accepted when full if a read fires the same cycle
// - Derived, not overridable:
//   - ADDR_WIDTH = max(1, clog2(DEPTH))
//   - CNT_WIDTH  = clog2(DEPTH+1)
// PORTS
// - clk                in   1           rising-edge clock
// - reset_n            in   1           asynchronous active-low reset
// - if_empty_n         out  1           1 = at least one entry valid
// - if_read_ce         in   1           read clock-enable
// - if_read            in   1           read request
// - if_dout            out  DATA_WIDTH  oldest entry; combinational from SRL
// - if_full_n          out  1           1 = space available
// - if_write_ce        in   1           write clock-enable
// - if_write           in   1           write request
// - if_din             in   DATA_WIDTH  write data
// - if_num_data_valid  out  CNT_WIDTH   current occupancy, 0..DEPTH
// - if_fifo_cap        out  CNT_WIDTH   constant DEPTH
// - if_almost_full     out  1           count >= AF_LEVEL
// - if_almost_empty    out  1           count <= AE_LEVEL
// - err_overflow       out  1           sticky: write requested while full and not accepted
// - err_underflow      out  1           sticky: read requested while empty
// BEHAVIOUR
// - Reset (async assert, sync-released by the system):
//   - count=0, if_empty_n=0, if_full_n=1, if_almost_empty=1.
//   - if_almost_full=0 (AF_LEVEL>=1).
//   - err_*=0, if_num_data_valid=0.
//   - SRL contents are not reset; if_dout is don't-care while empty.
// - Strobes: wr = if_write & if_write_ce; rd = if_read & if_read_ce.
// - Acceptance:
//   - rd_ok = rd & (count!=0).
//   - wr_ok = wr & ((count!=DEPTH) | (RW_WHEN_FULL & rd_ok)).
// - Storage:
//   - On wr_ok, the SRL shifts: entry[0] <= if_din, entry[i+1] <= entry[i].
//   - Read address = count-1 when count>0, else 0.
//   - if_dout is valid in the same cycle if_empty_n=1 (zero read latency).
//   - Write-to-visible latency is 1 cycle: if_empty_n rises the cycle after the first wr_ok.
// - Count update at the clock edge:
//   - wr_ok & !rd_ok: +1
//   - rd_ok & !wr_ok: -1
//   - both or neither: unchanged
// - Flags are all registered, computed from the next count; no combinational path input->flag:
//   - if_empty_n    = next!=0
//   - if_full_n     = next!=DEPTH
//   - if_almost_*   = next compared to AF_LEVEL / AE_LEVEL
// - Boundaries:
//   - Full, RW_WHEN_FULL=0, rd&wr: read accepted, write rejected, count=DEPTH-1.
//   - Full, RW_WHEN_FULL=1, rd&wr: both accepted, count stays DEPTH. if_dout this cycle is the oldest entry; the shift discards it at the edge.
//   - Empty, rd&wr: write only, count=1; the read is an underflow (err_underflow set).
//   - DEPTH=1: a single-register FIFO; ADDR_WIDTH=1, address tied to 0.
// - Error flags:
//   - err_overflow sets on wr & !wr_ok.
//   - err_underflow sets on rd & count==0.
//   - Both hold until reset_n; they never gate the handshake.
// - Reset mid-operation: all state clears immediately (async); in-flight tokens are lost; no X on any output.
// - Elaboration error if AF_LEVEL or AE_LEVEL is out of range, or DEPTH<1.
// STRUCTURE
// - Shared package/include kernel_pr_fifo_pkg:
//   - clog2 function;
//   - FIFO_MEM_SRL style constant;
//   - the ADDR_WIDTH/CNT_WIDTH derivation macros.
// - Sub-module kernel_pr_fifo_srl_stat_shiftReg: DATA_WIDTH x DEPTH SRL with ce and a combinational read mux. No reset, so it infers SRL primitives.
// - The top holds the count register, flag registers, error registers and acceptance logic.
// TESTING
// - Reset: DEPTH=4, assert reset_n=0 mid-stream with count=3 -> next sample count=0, if_empty_n=0, if_full_n=1, err_*=0.
// - Fill/drain: DEPTH=5, write 5,6,7,8,9:
//   - if_full_n=0 after the 5th write;
//   - if_almost_full rises at count=3;
//   - reads return 5..9 in order;
//   - if_empty_n=0 after the 5th read.
// - Simultaneous at full:
//   - RW_WHEN_FULL=0: count 4 -> 3, din dropped, err_overflow=1.
//   - RW_WHEN_FULL=1: count stays 4, dout=oldest, err_overflow=0, new word emerges last.
// - Empty rd+wr: count 0, rd&wr din=0xA -> count=1, if_empty_n=1 next cycle, err_underflow=1, dout=0xA.
// - Clock-enables: if_write=1, if_write_ce=0 for 3 cycles -> count unchanged, no errors; likewise for read.
// - DEPTH=1 and DEPTH=6 (non-power-of-2): random rd/wr for 10k cycles against a scoreboard model -> data order, if_num_data_valid and all flags match every cycle.

Source files
------------

// File: rtl/kernel_pr_fifo_pkg.sv
// Shared helpers for the kernel_pr FIFO family: width derivation and
// the memory-style tag used by the SRL variant.
package kernel_pr_fifo_pkg;

  typedef enum logic [1:0] {
    FIFO_MEM_SRL  = 2'd0,
    FIFO_MEM_BRAM = 2'd1,
    FIFO_MEM_AUTO = 2'd2
  } fifo_mem_style_e;

  localparam fifo_mem_style_e FIFO_MEM_STYLE = FIFO_MEM_SRL;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Address needs at least one bit so DEPTH=1 still has a legal port.
  function automatic int fifo_addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kernel_pr_fifo_srl_stat_shiftReg.sv
// DATA_WIDTH x DEPTH shift register with a combinational read mux.
// Deliberately reset-free so synthesis can map it onto SRL primitives.
module kernel_pr_fifo_srl_stat_shiftReg
  import kernel_pr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  always_comb begin
    dout = mem[0];
    for (int i = 1; i < DEPTH; i++)
      if (addr == ADDR_WIDTH'(i)) dout = mem[i];
  end

  if (DEPTH == 1) begin : g_single
    logic unused_addr;
    assign unused_addr = ^addr;
  end

endmodule

// File: rtl/kernel_pr_fifo_srl_stat.sv
// SRL FIFO with occupancy count, programmable almost flags, optional
// write-through-when-full and sticky overflow/underflow debug flags.
module kernel_pr_fifo_srl_stat
  import kernel_pr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int DEPTH        = 4,
  parameter int AF_LEVEL     = 3,
  parameter int AE_LEVEL     = 1,
  parameter int RW_WHEN_FULL = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  output logic                             if_empty_n,
  input  logic                             if_read_ce,
  input  logic                             if_read,
  output logic [DATA_WIDTH-1:0]            if_dout,
  output logic                             if_full_n,
  input  logic                             if_write_ce,
  input  logic                             if_write,
  input  logic [DATA_WIDTH-1:0]            if_din,
  output logic [fifo_cnt_w(DEPTH)-1:0]     if_num_data_valid,
  output logic [fifo_cnt_w(DEPTH)-1:0]     if_fifo_cap,
  output logic                             if_almost_full,
  output logic                             if_almost_empty,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  localparam int ADDR_WIDTH = fifo_addr_w(DEPTH);
  localparam int CNT_WIDTH  = fifo_cnt_w(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

  if (DEPTH < 1) begin : g_bad_depth
    $error("kernel_pr_fifo_srl_stat: DEPTH must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("kernel_pr_fifo_srl_stat: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("kernel_pr_fifo_srl_stat: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic                  wr, rd, wr_ok, rd_ok;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    wr    = if_write & if_write_ce;
    rd    = if_read & if_read_ce;
    rd_ok = rd && (cnt != '0);
    // A full FIFO can take a word only if the oldest one leaves this cycle.
    wr_ok = wr && ((cnt != FULL_CNT) || ((RW_WHEN_FULL != 0) && rd_ok));
    cnt_nxt = cnt;
    if (wr_ok && !rd_ok)      cnt_nxt = cnt + 1'b1;
    else if (rd_ok && !wr_ok) cnt_nxt = cnt - 1'b1;
  end

  if (DEPTH == 1) begin : g_addr_one
    assign rd_addr = '0;
  end else begin : g_addr_cnt
    assign rd_addr = (cnt != '0) ? ADDR_WIDTH'(cnt - 1'b1) : '0;
  end

  // Flags are registered from the next count so no input reaches them combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= '0;
      if_empty_n      <= 1'b0;
      if_full_n       <= 1'b1;
      if_almost_full  <= 1'b0;
      if_almost_empty <= 1'b1;
      err_overflow    <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      if_empty_n      <= (cnt_nxt != '0);
      if_full_n       <= (cnt_nxt != FULL_CNT);
      if_almost_full  <= (cnt_nxt >= AF_CNT);
      if_almost_empty <= (cnt_nxt <= AE_CNT);
      err_overflow    <= err_overflow | (wr & ~wr_ok);
      err_underflow   <= err_underflow | (rd & (cnt == '0));
    end
  end

  assign if_num_data_valid = cnt;
  assign if_fifo_cap       = FULL_CNT;

  kernel_pr_fifo_srl_stat_shiftReg #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_srl (
    .clk  (clk),
    .ce   (wr_ok),
    .din  (if_din),
    .addr (rd_addr),
    .dout (if_dout)
  );

endmodule

// File: tb/tb_kernel_pr_fifo_srl_stat.sv
// Five FIFO configurations driven by directed vectors and a random phase;
// a negedge monitor compares every instance against a queue model each cycle.
module tb_kernel_pr_fifo_srl_stat;

  localparam int N = 5;
  // inst: 0=D4/RW0  1=D4/RW1  2=D5  3=D1  4=D6/RW1
  localparam int DEP [N] = '{4, 4, 5, 1, 6};
  localparam int RWF [N] = '{0, 1, 0, 0, 1};
  localparam int AFL [N] = '{3, 3, 3, 1, 4};
  localparam int AEL [N] = '{1, 1, 1, 0, 2};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]      wr, wce, rd, rce, empty_n, full_n, afull, aempty, eov, eun;
  logic [N-1:0][3:0] din, dout, cnt, cap;

  int checks = 0;
  int fails  = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = $clog2(DEP[g] + 1);
    logic [CW-1:0] c, k;
    kernel_pr_fifo_srl_stat #(
      .DATA_WIDTH   (4),
      .DEPTH        (DEP[g]),
      .AF_LEVEL     (AFL[g]),
      .AE_LEVEL     (AEL[g]),
      .RW_WHEN_FULL (RWF[g])
    ) u_dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .if_empty_n        (empty_n[g]),
      .if_read_ce        (rce[g]),
      .if_read           (rd[g]),
      .if_dout           (dout[g]),
      .if_full_n         (full_n[g]),
      .if_write_ce       (wce[g]),
      .if_write          (wr[g]),
      .if_din            (din[g]),
      .if_num_data_valid (c),
      .if_fifo_cap       (k),
      .if_almost_full    (afull[g]),
      .if_almost_empty   (aempty[g]),
      .err_overflow      (eov[g]),
      .err_underflow     (eun[g])
    );
    assign cnt[g] = 4'(c);
    assign cap[g] = 4'(k);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: mm[i][0] is the oldest word, mc[i] the occupancy.
  logic [3:0] mm [N][8];
  int         mc [N];
  logic       mov [N];
  logic       mun [N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit w, r, rok, wok;
      if (!reset_n) begin
        mc[i] = 0; mov[i] = 1'b0; mun[i] = 1'b0;
      end
      chk($sformatf("cnt%0d", i),     cnt[i],     mc[i]);
      chk($sformatf("cap%0d", i),     cap[i],     DEP[i]);
      chk($sformatf("empty_n%0d", i), empty_n[i], mc[i] != 0);
      chk($sformatf("full_n%0d", i),  full_n[i],  mc[i] != DEP[i]);
      chk($sformatf("afull%0d", i),   afull[i],   mc[i] >= AFL[i]);
      chk($sformatf("aempty%0d", i),  aempty[i],  mc[i] <= AEL[i]);
      chk($sformatf("eov%0d", i),     eov[i],     mov[i]);
      chk($sformatf("eun%0d", i),     eun[i],     mun[i]);
      if (mc[i] > 0) chk($sformatf("dout%0d", i), dout[i], mm[i][0]);
      if (reset_n) begin
        w   = wr[i] & wce[i];
        r   = rd[i] & rce[i];
        rok = r && (mc[i] > 0);
        wok = w && ((mc[i] < DEP[i]) || (RWF[i] != 0 && rok));
        if (w && !wok) mov[i] = 1'b1;
        if (r && mc[i] == 0) mun[i] = 1'b1;
        if (rok) begin
          for (int j = 0; j < 7; j++) mm[i][j] = mm[i][j+1];
          mc[i]--;
        end
        if (wok) begin
          mm[i][mc[i]] = din[i];
          mc[i]++;
        end
      end
    end
  end

  task automatic step(input int i, input bit w, input bit r, input logic [3:0] d);
    wr[i] = w; rd[i] = r; din[i] = d;
    @(posedge clk); #1;
    wr[i] = 1'b0; rd[i] = 1'b0;
  endtask

  int af_exp [5] = '{0, 0, 1, 1, 1};
  logic [3:0] rw1_exp [4] = '{4'h2, 4'h3, 4'h4, 4'hE};

  initial begin
    wr = '0; rd = '0; wce = '1; rce = '1; din = '0; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_cnt", cnt[0], 0);
    chk("rst_empty_n", empty_n[0], 0);
    chk("rst_full_n", full_n[0], 1);
    chk("rst_aempty", aempty[0], 1);
    chk("rst_afull", afull[0], 0);
    chk("rst_err", {eov[0], eun[0]}, 0);

    // Reset mid-stream with three tokens in flight.
    for (int k = 1; k <= 3; k++) step(0, 1'b1, 1'b0, 4'(k));
    chk("mid_cnt", cnt[0], 3);
    reset_n = 1'b0;
    #2;
    chk("mrst_cnt", cnt[0], 0);
    chk("mrst_empty_n", empty_n[0], 0);
    chk("mrst_full_n", full_n[0], 1);
    chk("mrst_err", {eov[0], eun[0]}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Fill/drain DEPTH=5 with 5..9.
    for (int k = 0; k < 5; k++) begin
      step(2, 1'b1, 1'b0, 4'(5 + k));
      chk("fill_afull", afull[2], af_exp[k]);
      chk("fill_full_n", full_n[2], (k == 4) ? 0 : 1);
    end
    for (int k = 0; k < 5; k++) begin
      chk("drain_dout", dout[2], 5 + k);
      step(2, 1'b0, 1'b1, 4'h0);
      chk("drain_empty_n", empty_n[2], (k == 4) ? 0 : 1);
    end

    // Full with rd&wr, write-when-full disabled: write dropped.
    for (int k = 1; k <= 4; k++) step(0, 1'b1, 1'b0, 4'(k));
    chk("rw0_full_n", full_n[0], 0);
    step(0, 1'b1, 1'b1, 4'hF);
    chk("rw0_cnt", cnt[0], 3);
    chk("rw0_eov", eov[0], 1);
    for (int k = 2; k <= 4; k++) begin
      chk("rw0_dout", dout[0], k);
      step(0, 1'b0, 1'b1, 4'h0);
    end
    chk("rw0_cnt_end", cnt[0], 0);

    // Full with rd&wr, write-when-full enabled: both accepted.
    for (int k = 1; k <= 4; k++) step(1, 1'b1, 1'b0, 4'(k));
    chk("rw1_dout_old", dout[1], 1);
    step(1, 1'b1, 1'b1, 4'hE);
    chk("rw1_cnt", cnt[1], 4);
    chk("rw1_eov", eov[1], 0);
    for (int k = 0; k < 4; k++) begin
      chk("rw1_dout", dout[1], rw1_exp[k]);
      step(1, 1'b0, 1'b1, 4'h0);
    end

    // Empty with rd&wr: write only, underflow flagged.
    step(2, 1'b1, 1'b1, 4'hA);
    chk("erw_cnt", cnt[2], 1);
    chk("erw_empty_n", empty_n[2], 1);
    chk("erw_eun", eun[2], 1);
    chk("erw_dout", dout[2], 4'hA);
    step(2, 1'b0, 1'b1, 4'h0);

    // Clock-enables low block the strobes.
    wce[4] = 1'b0;
    repeat (3) step(4, 1'b1, 1'b0, 4'h3);
    wce[4] = 1'b1;
    chk("ce_w_cnt", cnt[4], 0);
    chk("ce_w_eov", eov[4], 0);
    step(4, 1'b1, 1'b0, 4'h7);
    rce[4] = 1'b0;
    repeat (3) step(4, 1'b0, 1'b1, 4'h0);
    rce[4] = 1'b1;
    chk("ce_r_cnt", cnt[4], 1);
    chk("ce_r_eun", eun[4], 0);
    chk("ce_r_dout", dout[4], 4'h7);
    step(4, 1'b0, 1'b1, 4'h0);

    // Random traffic on every instance, alternating fill- and drain-biased phases.
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      bit ph;
      ph = ((c / 150) % 2) != 0;
      for (int i = 0; i < N; i++) begin
        wr[i]  = $urandom_range(0, 3) < (ph ? 1 : 3);
        rd[i]  = $urandom_range(0, 3) < (ph ? 3 : 1);
        wce[i] = $urandom_range(0, 7) != 0;
        rce[i] = $urandom_range(0, 7) != 0;
        din[i] = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    wr = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
